// File: rtl/spi_slave_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_bridge_if
//  Brief    : SPI pins plus parallel word port between the bridge and its user
//  Revision : 1.0
// ============================================================================
interface spi_slave_bridge_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              byte_sync;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, data_out,
        output miso, miso_oe, byte_sync, data_in, frame_err, busy
    );

    modport master (
        output sclk, cs_n, mosi, data_out,
        input  miso, miso_oe, byte_sync, data_in, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_bridge
//  Brief    : SPI slave with input synchronisers, all four CPOL/CPHA modes,
//             configurable word width/bit order and framing-error reporting
//  Revision : 1.0
// ============================================================================
module spi_slave_bridge #(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_bridge_if.slave bus
);
    localparam int               CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_ACTIVE   = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_data_in;
    logic              r_miso;
    logic              r_byte_sync;
    logic              r_frame_err;

    logic              w_sclk_s;
    logic              w_cs_s;
    logic              w_mosi_s;
    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_shift;
    logic              w_tx_first;
    logic              w_tx_next;
    logic [DATA_W-1:0] w_tx_shift;
    logic [DATA_W-1:0] w_rx_next;

    // Chains reset to the bus idle levels so no false edge or select appears on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= CPOL;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_lead   = (w_sclk_s != CPOL) && (r_sclk_d == CPOL);
    assign w_trail  = (w_sclk_s == CPOL) && (r_sclk_d != CPOL);
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead  : w_trail;

    assign w_tx_first = MSB_FIRST ? bus.data_out[DATA_W-1] : bus.data_out[0];
    assign w_tx_next  = MSB_FIRST ? r_tx_sr[DATA_W-2]      : r_tx_sr[1];
    assign w_tx_shift = MSB_FIRST ? {r_tx_sr[DATA_W-2:0], 1'b0}
                                  : {1'b0, r_tx_sr[DATA_W-1:1]};
    assign w_rx_next  = MSB_FIRST ? {r_rx_sr[DATA_W-2:0], w_mosi_s}
                                  : {w_mosi_s, r_rx_sr[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_bit_cnt   <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_data_in   <= '0;
            r_miso      <= 1'b0;
            r_byte_sync <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_sync <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_cs_s) begin
                        r_state   <= c_ACTIVE;
                        r_bit_cnt <= '0;
                        r_rx_sr   <= '0;
                        if (!CPHA) begin
                            r_tx_sr <= bus.data_out;
                            r_miso  <= w_tx_first;
                        end
                    end
                end
                c_ACTIVE: begin
                    // Deselect takes priority over any edge seen in the same cycle.
                    if (w_cs_s) begin
                        r_state   <= c_IDLE;
                        r_miso    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_rx_sr   <= '0;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sample) begin
                        r_rx_sr <= w_rx_next;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_data_in   <= w_rx_next;
                            r_byte_sync <= 1'b1;
                            r_bit_cnt   <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_shift) begin
                        // Count of zero marks a word boundary: fetch a fresh reply word.
                        if (r_bit_cnt == '0) begin
                            r_tx_sr <= bus.data_out;
                            r_miso  <= w_tx_first;
                        end else begin
                            r_tx_sr <= w_tx_shift;
                            r_miso  <= w_tx_next;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.miso      = r_miso;
    assign bus.miso_oe   = (r_state == c_ACTIVE);
    assign bus.busy      = (r_state == c_ACTIVE);
    assign bus.byte_sync = r_byte_sync;
    assign bus.data_in   = r_data_in;
    assign bus.frame_err = r_frame_err;
endmodule
`default_nettype wire
